// File: rtl/cpu_loader_if.sv
// cpu_loader_if: byte-stream, memory write-port and cpu-control bundle around cpu_loader.
//   master: the stream source/system side (drives start, byte_valid, byte_data, cpu_idle).
//   slave : the loader (drives byte_ready, RAM/ROM write ports, cpu_setn, busy, done, run_cycles).
interface cpu_loader_if #(
    parameter int IMSB = 15,
    parameter int PMSB = 7,
    parameter int AMSB = 7,
    parameter int DMSB = 7
);
    logic            start;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            ram_we;
    logic [AMSB:0]   ram_addr;
    logic [DMSB:0]   ram_wdata;
    logic            rom_we;
    logic [PMSB:0]   rom_pc;
    logic [IMSB:0]   rom_inst;
    logic            cpu_setn;
    logic            cpu_idle;
    logic            busy;
    logic            done;
    logic [15:0]     run_cycles;

    modport master (
        output start, byte_valid, byte_data, cpu_idle,
        input  byte_ready, ram_we, ram_addr, ram_wdata, rom_we, rom_pc, rom_inst,
               cpu_setn, busy, done, run_cycles
    );

    modport slave (
        input  start, byte_valid, byte_data, cpu_idle,
        output byte_ready, ram_we, ram_addr, ram_wdata, rom_we, rom_pc, rom_inst,
               cpu_setn, busy, done, run_cycles
    );
endinterface

// File: rtl/cpu_loader.sv
// cpu_loader: boot loader writing a RAM image then a ROM image from a byte stream, then running the cpu.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset (shared with cpu.rstn)
//   bus  : cpu_loader_if.slave -- start, byte stream (valid/ready/data), RAM and ROM write ports,
//          cpu_setn/cpu_idle handshake with the cpu, busy/done status and run_cycles count.
module cpu_loader #(
    parameter int IMSB = 15,
    parameter int PMSB = 7,
    parameter int AMSB = 7,
    parameter int DMSB = 7
) (
    input logic          clk,
    input logic          rstn,
    cpu_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD_RAM, ROM_LO, ROM_HI, RUN, DONE} state_t;

    state_t        state;
    logic [AMSB:0] ra;
    logic [PMSB:0] pa;
    logic [7:0]    lo;
    logic [1:0]    settle;
    logic [15:0]   word;
    logic [DMSB:0] wd;
    logic [IMSB:0] wi;
    logic          xfer;

    assign xfer = bus.byte_valid && bus.byte_ready;
    assign word = {bus.byte_data, lo};

    // Zero-extend or truncate the stream byte / assembled word to the memory widths.
    always_comb begin
        wd = '0;
        wi = '0;
        for (int i = 0; i <= DMSB && i < 8; i++) wd[i] = bus.byte_data[i];
        for (int i = 0; i <= IMSB && i < 16; i++) wi[i] = word[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            ra             <= '0;
            pa             <= '0;
            lo             <= '0;
            settle         <= '0;
            bus.byte_ready <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.rom_we     <= 1'b0;
            bus.rom_pc     <= '0;
            bus.rom_inst   <= '0;
            bus.cpu_setn   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.run_cycles <= '0;
        end else begin
            bus.ram_we <= 1'b0;
            bus.rom_we <= 1'b0;
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state          <= LOAD_RAM;
                    ra             <= '0;
                    pa             <= '0;
                    bus.run_cycles <= '0;
                    bus.done       <= 1'b0;
                    bus.busy       <= 1'b1;
                    bus.byte_ready <= 1'b1;
                end
                LOAD_RAM: if (xfer) begin
                    bus.ram_we    <= 1'b1;
                    bus.ram_addr  <= ra;
                    bus.ram_wdata <= wd;
                    ra            <= ra + 1'b1;
                    if (&ra) state <= ROM_LO;
                end
                ROM_LO: if (xfer) begin
                    lo    <= bus.byte_data;
                    state <= ROM_HI;
                end
                ROM_HI: if (xfer) begin
                    bus.rom_we   <= 1'b1;
                    bus.rom_pc   <= pa;
                    bus.rom_inst <= wi;
                    pa           <= pa + 1'b1;
                    state        <= (&pa) ? RUN : ROM_LO;
                    if (&pa) begin
                        bus.byte_ready <= 1'b0;
                        bus.cpu_setn   <= 1'b1;
                        settle         <= '0;
                    end
                end
                RUN: begin
                    bus.run_cycles <= (&bus.run_cycles) ? bus.run_cycles : bus.run_cycles + 1'b1;
                    // cpu_idle is ignored for the first two RUN cycles while the cpu fetches its first instruction.
                    if (settle != 2'd2) settle <= settle + 1'b1;
                    else if (bus.cpu_idle) begin
                        state        <= DONE;
                        bus.cpu_setn <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: directed self-checking bench for cpu_loader (load, run, ignored start, async reset).
module tb_cpu_loader;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cpu_loader_if bus ();

    cpu_loader dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.byte_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rom_we, bus.rom_pc,
                bus.rom_inst, bus.cpu_setn, bus.busy, bus.done, bus.run_cycles};
    endfunction

    function automatic logic [63:0] strobes();
        return {bus.ram_we, bus.rom_we, bus.ram_we ? {bus.ram_addr, bus.ram_wdata} : 16'h0,
                bus.rom_we ? {bus.rom_pc, bus.rom_inst} : 24'h0};
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_busy_ready_done_rc", {bus.busy, bus.byte_ready, bus.done, bus.run_cycles}, 19'h6_0000);
    endtask

    // Streams byte k = k mod 256 until nbytes are accepted; checks ready and each write strobe.
    task automatic load(input bit gap, input int nbytes, input bit start_in_hi);
        int k = 0;
        int c = 0;
        bit x;
        logic [7:0] kb, lb, pc;
        logic [63:0] e;
        while (k < nbytes && c < 4000) begin
            bus.byte_valid = gap ? ~c[0] : 1'b1;
            bus.byte_data  = k[7:0];
            bus.start      = start_in_hi && k >= 256 && k[0];
            chk("byte_ready", bus.byte_ready, 1);
            x = bus.byte_valid;
            @(posedge clk); #1;
            c++;
            kb = k[7:0];
            lb = kb - 8'd1;
            pc = 8'((k - 256) / 2);
            e = !x ? 64'h0 : k < 256 ? {2'b10, kb, kb, 24'h0} : k[0] ? {2'b01, 16'h0, pc, kb, lb} : 64'h0;
            chk("write_strobe", strobes(), e);
            if (x) k++;
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        chk("load_bytes", k, nbytes);
        if (nbytes == 768) chk("release_setn_ready", {bus.cpu_setn, bus.byte_ready, bus.busy}, 3'b101);
    endtask

    // cpu_idle goes high on the n-th RUN cycle; exit happens no earlier than the 3rd.
    task automatic run_to_done(input int n);
        int ex = n < 3 ? 3 : n;
        for (int i = 1; i <= ex; i++) begin
            bus.cpu_idle = (i >= n);
            @(posedge clk); #1;
            chk("run_setn_done_busy", {bus.cpu_setn, bus.done, bus.busy}, i < ex ? 3'b101 : 3'b010);
        end
        chk("run_cycles", bus.run_cycles, ex);
        bus.cpu_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_hold", {bus.done, bus.cpu_setn, bus.run_cycles}, {2'b10, 16'(ex)});
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        bus.cpu_idle   = 1'b0;
        #12;
        chk("reset_outputs", all_outs(), 64'h0);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_no_strobe", {bus.byte_ready, bus.busy, strobes()}, 64'h0);
        end
        bus.byte_valid = 1'b0;

        pulse_start();
        load(1'b0, 768, 1'b0);
        run_to_done(1);

        pulse_start();
        load(1'b1, 768, 1'b0);
        run_to_done(10);

        pulse_start();
        load(1'b0, 768, 1'b1);
        run_to_done(1);

        pulse_start();
        load(1'b0, 256 + 2 * 40 + 1, 1'b0);
        bus.byte_valid = 1'b1;
        #3 rstn = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'h0);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_quiet", {bus.byte_ready, bus.busy, bus.cpu_setn, strobes()}, 64'h0);
        end
        bus.byte_valid = 1'b0;
        pulse_start();
        load(1'b0, 768, 1'b0);
        run_to_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
